// File: rtl/aqp_esp_uart_pkg.sv
// Shared types and constants for the ESP link UART receiver.
// Word layout pushed into the receive FIFO: {brk_flag, byte}.
package aqp_esp_uart_pkg;

   localparam int ESP_WORD_W  = 9;
   localparam int ESP_BRK_BIT = 8;

   // Receiver frame states; PARITY is only reachable in 8E1 builds.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_e;

endpackage

// File: rtl/aqp_esp_uart_rx_fifo.sv
// Synchronous receive FIFO for ESP words.
// Pointers carry one extra wrap bit so all 2**FIFO_AW entries are usable.
// A pop registers mem[rdptr] into rddata; rddata holds otherwise.
// A write into a full FIFO is ignored, even when a pop happens the same cycle.
module aqp_esp_uart_rx_fifo
   import aqp_esp_uart_pkg::*;
#(
   parameter int FIFO_AW = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ESP_WORD_W-1:0] wrdata,
   input  logic                  wr_en,
   output logic [ESP_WORD_W-1:0] rddata,
   input  logic                  rd_en,
   output logic                  empty,
   output logic                  full,
   output logic [FIFO_AW:0]      count
);

   localparam int DEPTH = 2 ** FIFO_AW;

   logic [ESP_WORD_W-1:0] mem_q [DEPTH];
   logic [FIFO_AW:0]      wrptr_q;
   logic [FIFO_AW:0]      rdptr_q;
   logic [ESP_WORD_W-1:0] rddata_q;
   logic                  do_wr;
   logic                  do_rd;

   assign empty  = (wrptr_q == rdptr_q);
   assign full   = (wrptr_q[FIFO_AW-1:0] == rdptr_q[FIFO_AW-1:0]) &&
                   (wrptr_q[FIFO_AW] != rdptr_q[FIFO_AW]);
   assign count  = wrptr_q - rdptr_q;
   assign do_wr  = wr_en && !full;
   assign do_rd  = rd_en && !empty;
   assign rddata = rddata_q;

   // Pointer and read-data registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrptr_q  <= '0;
         rdptr_q  <= '0;
         rddata_q <= '0;
      end else begin
         if (do_wr) wrptr_q <= wrptr_q + 1'b1;
         if (do_rd) begin
            rddata_q <= mem_q[rdptr_q[FIFO_AW-1:0]];
            rdptr_q  <= rdptr_q + 1'b1;
         end
      end
   end

   // Storage array write port.
   // NOTE: the array has no reset so it maps onto distributed RAM; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wrptr_q[FIFO_AW-1:0]] <= wrdata;
   end

endmodule

// File: rtl/aqp_esp_uart_rx.sv
// UART receiver for the ESP link: 8N1 frames into 9-bit {brk_flag, byte}
// words, buffered in a FIFO, with RTS flow control back to the ESP.
// Optional build macro AQP_ESP_UART_RX_PARITY_EN selects 8E1 framing and
// adds the sticky parity_err output.
module aqp_esp_uart_rx
   import aqp_esp_uart_pkg::*;
#(
   parameter int BIT_CYCLES = 25,
   parameter int FIFO_AW    = 4,
   parameter int RTS_MARGIN = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_rxd,
   output logic                  uart_rts_n,
   output logic [ESP_WORD_W-1:0] rddata,
   input  logic                  rd_en,
   output logic                  empty,
   output logic                  full,
   output logic                  framing_err,
   output logic                  overflow_err,
`ifdef AQP_ESP_UART_RX_PARITY_EN
   output logic                  parity_err,
`endif
   input  logic                  err_clr
);

   localparam int CNT_W = $clog2(BIT_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_HALF  = CNT_W'(BIT_CYCLES / 2 - 1);
   localparam logic [FIFO_AW:0]   RTS_LEVEL = (FIFO_AW + 1)'(2 ** FIFO_AW - RTS_MARGIN);

   logic                  rx_meta_q;
   logic                  rxs_q;
   rx_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            bit_idx_q, bit_idx_d;
   logic [7:0]            shift_q, shift_d;
   logic                  brk_pending_q, brk_pending_d;
   logic                  push;
   logic                  set_framing;
   logic [ESP_WORD_W-1:0] push_word;
   logic                  brk_par_ok;
   logic                  push_ok;
   logic                  framing_err_q;
   logic                  overflow_err_q;
   logic                  rts_n_q;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FIFO_AW:0]      fifo_count;

`ifdef AQP_ESP_UART_RX_PARITY_EN
   logic par_bit_q, par_bit_d;
   logic par_bad_q, par_bad_d;
   logic set_parity;
   logic parity_err_q;

   // A break must also have a low parity bit; a bad parity byte is never pushed.
   assign brk_par_ok = !par_bit_q;
   assign push_ok    = !par_bad_q;
   assign parity_err = parity_err_q;
`else
   assign brk_par_ok = 1'b1;
   assign push_ok    = 1'b1;
`endif

   assign push_word[ESP_BRK_BIT]     = brk_pending_q;
   assign push_word[ESP_BRK_BIT-1:0] = shift_q;

   // Two-flop synchroniser for the asynchronous serial input; idles high.
   // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= uart_rxd;
         rxs_q     <= rx_meta_q;
      end
   end

   // Receiver state register: FSM, bit timer, data shifter, break marker.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         brk_pending_q <= 1'b0;
`ifdef AQP_ESP_UART_RX_PARITY_EN
         par_bit_q     <= 1'b0;
         par_bad_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         brk_pending_q <= brk_pending_d;
`ifdef AQP_ESP_UART_RX_PARITY_EN
         par_bit_q     <= par_bit_d;
         par_bad_q     <= par_bad_d;
`endif
      end
   end

   // Next-state logic: mid-bit sampling, frame decode, push and error events.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d       = state_q;
      cnt_d         = cnt_q + 1'b1;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      brk_pending_d = brk_pending_q;
      push          = 1'b0;
      set_framing   = 1'b0;
`ifdef AQP_ESP_UART_RX_PARITY_EN
      par_bit_d     = par_bit_q;
      par_bad_d     = par_bad_q;
      set_parity    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxs_q) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rxs_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rxs_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) begin
`ifdef AQP_ESP_UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef AQP_ESP_UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d      = '0;
               par_bit_d  = rxs_q;
               // Even parity: data ones plus parity bit must be even.
               par_bad_d  = (rxs_q != ^shift_q);
               set_parity = (rxs_q != ^shift_q);
               state_d    = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rxs_q) begin
                  push          = push_ok;
                  brk_pending_d = 1'b0;
                  state_d       = IDLE;
               end else if (shift_q == 8'h00 && brk_par_ok) begin
                  brk_pending_d = 1'b1;
                  state_d       = WAIT_HIGH;
               end else begin
                  set_framing = 1'b1;
                  state_d     = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rxs_q) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Sticky error flags and registered RTS; a set event beats err_clr.
   always_ff @(posedge clk) begin
      if (reset) begin
         framing_err_q  <= 1'b0;
         overflow_err_q <= 1'b0;
         rts_n_q        <= 1'b0;
`ifdef AQP_ESP_UART_RX_PARITY_EN
         parity_err_q   <= 1'b0;
`endif
      end else begin
         framing_err_q  <= set_framing | (framing_err_q & ~err_clr);
         overflow_err_q <= (push & fifo_full) | (overflow_err_q & ~err_clr);
         rts_n_q        <= (fifo_count >= RTS_LEVEL);
`ifdef AQP_ESP_UART_RX_PARITY_EN
         parity_err_q   <= set_parity | (parity_err_q & ~err_clr);
`endif
      end
   end

   aqp_esp_uart_rx_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .wrdata (push_word),
      .wr_en  (push),
      .rddata (rddata),
      .rd_en  (rd_en),
      .empty  (fifo_empty),
      .full   (fifo_full),
      .count  (fifo_count)
   );

   assign empty        = fifo_empty;
   assign full         = fifo_full;
   assign uart_rts_n   = rts_n_q;
   assign framing_err  = framing_err_q;
   assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_aqp_esp_uart_rx.sv
// Self-checking bench for aqp_esp_uart_rx: directed scenarios followed by
// randomized traffic, all compared against a frame-level reference model.
module tb_aqp_esp_uart_rx;

   localparam int BC         = 8;
   localparam int AW         = 4;
   localparam int DEPTH      = 2 ** AW;
   localparam int RTS_MARGIN = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       uart_rxd;
   logic       uart_rts_n;
   logic [8:0] rddata;
   logic       rd_en;
   logic       empty;
   logic       full;
   logic       framing_err;
   logic       overflow_err;
   logic       err_clr;
`ifdef AQP_ESP_UART_RX_PARITY_EN
   logic       parity_err;
`endif

   aqp_esp_uart_rx #(
      .BIT_CYCLES (BC),
      .FIFO_AW    (AW),
      .RTS_MARGIN (RTS_MARGIN)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .uart_rxd     (uart_rxd),
      .uart_rts_n   (uart_rts_n),
      .rddata       (rddata),
      .rd_en        (rd_en),
      .empty        (empty),
      .full         (full),
      .framing_err  (framing_err),
      .overflow_err (overflow_err),
`ifdef AQP_ESP_UART_RX_PARITY_EN
      .parity_err   (parity_err),
`endif
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: queued words and expected sticky flags.
   logic [8:0] exp_q[$];
   bit         m_brk;
   bit         m_frm;
   bit         m_ovf;
   bit         m_par;
   logic [8:0] m_rd;

   // Cycle bookkeeping for the first-word latency measurement.
   int cyc       = 0;
   int start_cyc = 0;
   int push_cyc  = 0;
   bit prev_empty = 1'b1;

   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (prev_empty && !empty) push_cyc = cyc;
      prev_empty = empty;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input bit v, input int nbits);
      uart_rxd = v;
      repeat (nbits * BC) @(negedge clk);
   endtask

   // Serialise one frame and update the model from the frame rules.
   task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_bit);
      bit par_ok;
      bit brk_ok;
      par_ok = 1'b1;
      brk_ok = 1'b1;
      start_cyc = cyc;
      drive(1'b0, 1);
      for (int i = 0; i < 8; i++) drive(b[i], 1);
`ifdef AQP_ESP_UART_RX_PARITY_EN
      drive(par_bit, 1);
      par_ok = (par_bit == ^b);
      brk_ok = (par_bit == 1'b0);
      if (!par_ok) m_par = 1'b1;
`endif
      drive(stop_bit, 1);
      uart_rxd = 1'b1;
      idle(4);
      if (stop_bit) begin
         if (par_ok) begin
            if (exp_q.size() == DEPTH) m_ovf = 1'b1;
            else exp_q.push_back({m_brk, b});
         end
         m_brk = 1'b0;
      end else if (b == 8'h00 && brk_ok) begin
         m_brk = 1'b1;
      end else begin
         m_frm = 1'b1;
      end
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, 1'b1, ^b);
   endtask

   // Line held low for nbits bit times (>= one whole frame) is a break.
   task automatic send_break(input int nbits);
      drive(1'b0, nbits);
      drive(1'b1, 1);
      idle(4);
      m_brk = 1'b1;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      if (exp_q.size() > 0) begin
         m_rd = exp_q.pop_front();
         check("rddata pop", rddata, m_rd);
      end else begin
         check("rddata hold on empty pop", rddata, m_rd);
      end
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_frm = 1'b0;
      m_ovf = 1'b0;
      m_par = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      exp_q.delete();
      m_brk = 1'b0;
      m_frm = 1'b0;
      m_ovf = 1'b0;
      m_par = 1'b0;
      m_rd  = '0;
   endtask

   // Compare all status outputs; one idle cycle first lets RTS catch up.
   task automatic check_status(input string ctx);
      @(negedge clk);
      check({ctx, " empty"}, empty, exp_q.size() == 0);
      check({ctx, " full"}, full, exp_q.size() == DEPTH);
      check({ctx, " rts_n"}, uart_rts_n, exp_q.size() >= DEPTH - RTS_MARGIN);
      check({ctx, " framing_err"}, framing_err, m_frm);
      check({ctx, " overflow_err"}, overflow_err, m_ovf);
`ifdef AQP_ESP_UART_RX_PARITY_EN
      check({ctx, " parity_err"}, parity_err, m_par);
`endif
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int r;
      int n;
      reset    = 1'b1;
      uart_rxd = 1'b1;
      rd_en    = 1'b0;
      err_clr  = 1'b0;
      idle(1);
      do_reset();
      check_status("reset");
      check("reset rddata", rddata, 9'h000);

      // First word and its arrival latency from the start edge.
      send_good(8'h5A);
      check("t1 latency", ((push_cyc - start_cyc) >= 9 * BC + BC / 2 + 1) &&
                          ((push_cyc - start_cyc) <= 9 * BC + BC / 2 + 5), 1);
      check_status("t1 queued");
      pop();
      check_status("t1 popped");

      // Long break marks the next byte only.
      send_break(20);
      send_good(8'h41);
      send_good(8'h42);
      check_status("t2 queued");
      pop();
      pop();
      check_status("t2 popped");

      // Framing error, then clear it.
      send_frame(8'h33, 1'b0, ^8'h33);
      check_status("t3 framing");
      pulse_err_clr();
      check_status("t3 cleared");

      // Fill past the RTS threshold, then overflow.
      for (int i = 0; i < 17; i++) begin
         send_good(8'(8'h80 + i));
         check_status($sformatf("t4 fill %0d", i + 1));
      end
      for (int i = 0; i < DEPTH; i++) pop();
      check_status("t4 drained");
      pop();
      pulse_err_clr();

      // Short glitch is rejected; the receiver still takes a real frame after.
      uart_rxd = 1'b0;
      idle(2);
      uart_rxd = 1'b1;
      idle(3 * BC);
      check_status("t5 glitch");
      send_good(8'h11);
      check_status("t5 after glitch");

      // Reset in the middle of the data bits of 0xFF.
      send_frame(8'h22, 1'b0, ^8'h22);
      uart_rxd = 1'b0;
      idle(BC);
      uart_rxd = 1'b1;
      idle(3 * BC);
      do_reset();
      idle(10 * BC);
      check_status("t5 mid-frame reset");
      check("t5 reset rddata", rddata, 9'h000);

`ifdef AQP_ESP_UART_RX_PARITY_EN
      // Wrong even parity on 0x07 is dropped; correct parity is accepted.
      send_frame(8'h07, 1'b1, 1'b0);
      check_status("t6 bad parity");
      send_frame(8'h07, 1'b1, 1'b1);
      check_status("t6 good parity");
      pop();
      pulse_err_clr();
      check_status("t6 cleared");
`endif

      // Randomized traffic against the model.
      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 99);
         if (r < 55) begin
            send_good(8'($urandom_range(0, 255)));
         end else if (r < 62) begin
            send_frame(8'($urandom_range(1, 255)), 1'b0, 1'b0);
         end else if (r < 67) begin
            send_break($urandom_range(12, 30));
         end else if (r < 72) begin
`ifdef AQP_ESP_UART_RX_PARITY_EN
            n = $urandom_range(0, 255);
            send_frame(8'(n), 1'b1, ~(^8'(n)));
`else
            send_good(8'($urandom_range(0, 255)));
`endif
         end else if (r < 92) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) pop();
         end else begin
            pulse_err_clr();
         end
         check_status($sformatf("rand %0d", it));
      end

      while (exp_q.size() > 0) pop();
      check_status("final drain");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
